// File: rtl/ysyx_22050078_pc_fetch_ctrl_pkg.sv
// ============================================================================
// ysyx_22050078_pc_fetch_ctrl_pkg : shared FSM encoding and PC constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22050078_pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_WAIT = 2'd1,
    PF_HOLD = 2'd2
  } pf_state_e;

  localparam logic [63:0] PF_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned PC_STEP     = 4;

endpackage

`default_nettype wire

// File: rtl/ysyx_22050078_pc_fetch_ctrl_reg.sv
// ============================================================================
// ysyx_22050078_Reg : generic register with write enable and sync reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050078_Reg #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_o <= RESET_VAL;
    end else if (wen_i) begin
      dout_o <= din_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22050078_pc_fetch_ctrl.sv
// ============================================================================
// ysyx_22050078_pc_fetch_ctrl : PC owner, single-outstanding fetch, redirect
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050078_pc_fetch_ctrl
  import ysyx_22050078_pc_fetch_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = PF_RESET_PC[ADDR_WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [INST_WIDTH-1:0] mem_resp_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pc_we;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  inst_we;
  logic [1:0]            state_raw_q;
  pf_state_e             state_q, state_d;
  logic                  kill_q, kill_d;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  assign state_q      = pf_state_e'(state_raw_q);
  assign redirect_tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    pc_d    = pc_q;
    pc_we   = 1'b0;
    inst_we = 1'b0;
    state_d = state_q;
    kill_d  = kill_q;
    if (redirect_valid) begin
      pc_d  = redirect_tgt;
      pc_we = 1'b1;
      // A response landing in the redirect cycle is simply dropped; otherwise
      // the outstanding one must be killed when it eventually shows up.
      if (state_q == PF_WAIT && !mem_resp_valid) begin
        kill_d = 1'b1;
      end else begin
        kill_d  = 1'b0;
        state_d = PF_IDLE;
      end
    end else begin
      case (state_q)
        PF_IDLE: begin
          if (mem_req_ready) state_d = PF_WAIT;
        end
        PF_WAIT: begin
          if (mem_resp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = PF_IDLE;
            end else begin
              inst_we = 1'b1;
              state_d = PF_HOLD;
            end
          end
        end
        PF_HOLD: begin
          if (out_ready) begin
            pc_d    = pc_q + ADDR_WIDTH'(PC_STEP);
            pc_we   = 1'b1;
            state_d = PF_IDLE;
          end
        end
        default: state_d = PF_IDLE;
      endcase
    end
  end

  ysyx_22050078_Reg #(.WIDTH(ADDR_WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (pc_we),
    .din_i  (pc_d),
    .dout_o (pc_q)
  );

  ysyx_22050078_Reg #(.WIDTH(INST_WIDTH), .RESET_VAL('0)) u_inst_reg (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (inst_we),
    .din_i  (mem_resp_inst),
    .dout_o (inst_q)
  );

  ysyx_22050078_Reg #(.WIDTH(2), .RESET_VAL(PF_IDLE)) u_state_reg (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (1'b1),
    .din_i  (state_d),
    .dout_o (state_raw_q)
  );

  ysyx_22050078_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_kill_reg (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (1'b1),
    .din_i  (kill_d),
    .dout_o (kill_q)
  );

  // Handshake-facing valids are gated by rst so nothing escapes the reset cycle.
  assign mem_req_valid = !rst && (state_q == PF_IDLE) && !redirect_valid;
  assign mem_req_addr  = pc_q;
  assign out_valid     = !rst && (state_q == PF_HOLD) && !redirect_valid;
  assign out_pc        = (state_q == PF_HOLD) ? pc_q   : '0;
  assign out_inst      = (state_q == PF_HOLD) ? inst_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050078_pc_fetch_ctrl.sv
// ============================================================================
// tb_ysyx_22050078_pc_fetch_ctrl : directed + random bench with reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050078_pc_fetch_ctrl;

  localparam logic [63:0] C_RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  int n_vec;
  int n_err;

  // Transaction-level model: an outstanding request, whether it was
  // cancelled, and whether an instruction is waiting for the consumer.
  logic [63:0] m_pc;
  bit          m_outstanding;
  bit          m_cancelled;
  bit          m_have;
  logic [31:0] m_inst;

  ysyx_22050078_pc_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_inst  (mem_resp_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [63:0] rp,
                      input bit qr, input bit sv, input logic [31:0] si,
                      input bit ordy);
    logic [63:0] tgt;
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    mem_req_ready  = qr;
    mem_resp_valid = sv;
    mem_resp_inst  = si;
    out_ready      = ordy;
    #1;
    chk("mem_req_valid", {63'd0, mem_req_valid},
        {63'd0, (!r && !m_outstanding && !m_have && !rv)});
    chk("mem_req_addr", mem_req_addr, m_pc);
    chk("out_valid", {63'd0, out_valid}, {63'd0, (!r && m_have && !rv)});
    chk("out_pc", out_pc, m_have ? m_pc : 64'd0);
    chk("out_inst", {32'd0, out_inst}, {32'd0, (m_have ? m_inst : 32'd0)});
    tgt = rp & ~64'd3;
    if (r) begin
      m_pc = C_RESET_PC; m_outstanding = 0; m_cancelled = 0; m_have = 0; m_inst = '0;
    end else if (rv) begin
      m_pc   = tgt;
      m_have = 0;
      if (m_outstanding) begin
        if (sv) begin m_outstanding = 0; m_cancelled = 0; end
        else m_cancelled = 1;
      end
    end else if (m_have) begin
      if (ordy) begin m_pc = m_pc + 64'd4; m_have = 0; end
    end else if (m_outstanding) begin
      if (sv) begin
        m_outstanding = 0;
        if (m_cancelled) m_cancelled = 0;
        else begin m_have = 1; m_inst = si; end
      end
    end else if (qr) begin
      m_outstanding = 1;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_inst = '0; out_ready = 1'b0;
    m_pc = C_RESET_PC; m_outstanding = 0; m_cancelled = 0; m_have = 0; m_inst = '0;

    step(1, 0, 0, 1, 0, 0, 1);
    chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);

    // Basic fetch, 1-cycle memory
    step(0, 0, 0, 1, 0, 0, 1);
    chk("c0_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("c0_addr", mem_req_addr, 64'h8000_0000);
    step(0, 0, 0, 1, 1, 32'h0000_0413, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("c2_out_valid", {63'd0, out_valid}, 64'd1);
    chk("c2_out_pc", out_pc, 64'h8000_0000);
    chk("c2_out_inst", {32'd0, out_inst}, 64'h413);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("next_addr", mem_req_addr, 64'h8000_0004);

    // HOLD stall for 5 cycles
    step(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      chk("stall_pc", out_pc, 64'h8000_0004);
    end
    step(0, 0, 0, 1, 0, 0, 1);

    // Redirect in WAIT, response 2 cycles later is dropped
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 64'h8000_0103, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'h1111_1111, 1);
    chk("kill_no_out", {63'd0, out_valid}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("kill_addr", mem_req_addr, 64'h8000_0100);
    chk("kill_req", {63'd0, mem_req_valid}, 64'd1);

    // Redirect in HOLD with out_ready high
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h2222_2222, 0);
    step(0, 1, 64'h8000_0200, 1, 0, 0, 1);
    chk("hold_redir_gate", {63'd0, out_valid}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("hold_redir_addr", mem_req_addr, 64'h8000_0200);

    // Memory backpressure
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'h3333_3333, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // PC wrap, then reset during WAIT with a late response
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("wrap_addr_hi", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 1, 1, 32'h4444_4444, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_addr_lo", mem_req_addr, 64'd0);
    step(0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'h5555_5555, 1);
    chk("late_resp_addr", mem_req_addr, C_RESET_PC);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("late_resp_ignored", {63'd0, out_valid}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0),
           ($urandom_range(9) == 0),
           {$urandom, $urandom},
           ($urandom_range(9) < 7),
           ($urandom_range(1) == 1),
           $urandom,
           ($urandom_range(9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
